vram_fetch: RTL

VRAM_FETCH -- requirements
Module: vram_fetch

---
 rtl/vga_pkg.sv | 15 +
 rtl/vram_fetch_sync_fifo.sv | 89 ++++++++
 rtl/vram_fetch.sv | 109 ++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared defaults and fetch FSM state encoding for the VGA frame fetch path.
package vga_pkg;

    localparam int unsigned VGA_AWIDTH      = 19;
    localparam int unsigned VGA_DWIDTH      = 8;
    localparam int unsigned VGA_FRAME_BYTES = 307200;
    localparam int unsigned VGA_FIFO_DEPTH  = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/vram_fetch_sync_fifo.sv
// Pixel byte FIFO with registered head data, empty and full flags.
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
    parameter int unsigned DWIDTH = 8,
    parameter int unsigned DEPTH  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [DWIDTH-1:0] wdata_i,
    output logic [DWIDTH-1:0] rdata_o,
    output logic              empty_o,
    output logic              full_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [DWIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]     wr_q, wr_d;
    logic [PW-1:0]     rd_q, rd_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DWIDTH-1:0] rdata_q, rdata_d;
    logic              empty_q, full_q;
    logic              push_ok, pop_ok;

    assign pop_ok  = pop_i & ~empty_q;
    assign push_ok = push_i & (~full_q | pop_ok);

    // Next pointers, occupancy and the head byte as seen after this cycle
    always_comb begin
        wr_d    = wr_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        rdata_d = '0;
        if (flush_i) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (push_ok) wr_d = wr_q + 1'b1;
            if (pop_ok)  rd_d = rd_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end
        // The head slot may be the one being written this very cycle
        if (cnt_d == '0)
            rdata_d = '0;
        else if (push_ok && (wr_q == rd_d))
            rdata_d = wdata_i;
        else
            rdata_d = mem_q[rd_d];
    end

    // Storage array; nothing is written on reset or flush cycles
    always_ff @(posedge clk_i) begin
        if (push_ok && !flush_i && !rst_i)
            mem_q[wr_q] <= wdata_i;
    end

    // Pointer, count and flag registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            empty_q <= (cnt_d == '0);
            full_q  <= (cnt_d == CW'(DEPTH));
        end
    end

    assign rdata_o = rdata_q;
    assign empty_o = empty_q;
    assign full_o  = full_q;

endmodule

// File: rtl/vram_fetch.sv
// Frame fetcher: walks VRAM addresses from FrameBase, buffers returned bytes
// in a FIFO for the pixel consumer and flags frame completion.
// Optional feature macro: VRAM_FETCH_UNDERRUN_EN (sticky underrun flag).
module vram_fetch
    import vga_pkg::*;
#(
    parameter int unsigned AWIDTH      = VGA_AWIDTH,
    parameter int unsigned DWIDTH      = VGA_DWIDTH,
    parameter int unsigned FRAME_BYTES = VGA_FRAME_BYTES,
    parameter int unsigned FIFO_DEPTH  = VGA_FIFO_DEPTH
) (
    input  logic              MemClk,
    input  logic              Reset,
    input  logic [AWIDTH-1:0] FrameBase,
    input  logic              Enable,
    input  logic              FrameStart,
    output logic [AWIDTH-1:0] ReqAddr,
    input  logic [DWIDTH-1:0] ReadData,
    input  logic              ReadDataRdy,
    output logic [DWIDTH-1:0] PixData,
    output logic              PixValid,
    input  logic              PixReady,
    output logic              FrameDone,
    output logic              Underrun
);

    localparam int unsigned CNTW = $clog2(FRAME_BYTES + 1);

    fetch_state_e      state_q;
    logic [AWIDTH-1:0] addr_q;
    logic [CNTW-1:0]   count_q;
    logic              done_q;

    logic              restart;
    logic              flush;
    logic              pop;
    logic              accept;
    logic              fifo_empty;
    logic              fifo_full;
    logic [DWIDTH-1:0] fifo_rdata;

    assign restart = Enable & FrameStart;
    assign flush   = ~Enable | restart;
    assign pop     = ~fifo_empty & PixReady;
    // A full FIFO still takes the byte when the consumer pops in the same cycle
    assign accept  = (state_q == ST_RUN) & ~flush & ReadDataRdy & (~fifo_full | pop);

    sync_fifo #(
        .DWIDTH (DWIDTH),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (MemClk),
        .rst_i   (Reset),
        .flush_i (flush),
        .push_i  (accept),
        .pop_i   (pop),
        .wdata_i (ReadData),
        .rdata_o (fifo_rdata),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    // Fetch FSM with address/byte counters; restart beats a coincident accept
    always_ff @(posedge MemClk) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
        end else if (!Enable) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
        end else if (FrameStart) begin
            state_q <= ST_RUN;
            addr_q  <= FrameBase;
            count_q <= '0;
            done_q  <= 1'b0;
        end else if (accept) begin
            addr_q  <= addr_q + 1'b1;
            count_q <= count_q + 1'b1;
            if (count_q == CNTW'(FRAME_BYTES - 1)) begin
                state_q <= ST_DONE;
                done_q  <= 1'b1;
            end
        end
    end

`ifdef VRAM_FETCH_UNDERRUN_EN
    logic underrun_q;

    // Sticky flag: consumer asked for a pixel while RUN had nothing buffered
    always_ff @(posedge MemClk) begin
        if (Reset || restart)
            underrun_q <= 1'b0;
        else if ((state_q == ST_RUN) && PixReady && fifo_empty)
            underrun_q <= 1'b1;
    end

    assign Underrun = underrun_q;
`else
    assign Underrun = 1'b0;
`endif

    assign ReqAddr   = addr_q;
    assign PixData   = fifo_rdata;
    assign PixValid  = ~fifo_empty;
    assign FrameDone = done_q;

endmodule
